// File: rtl/tone_i2s_tx_if.sv
// rtl/tone_i2s_tx_if.sv - note/volume controls and Pmod I2S DAC pins of the tone output stage
interface tone_i2s_tx_if #(
  parameter int DIV_W = 22
);
  logic [DIV_W-1:0] note_div;
  logic [2:0]       volume;
  logic             audio_mclk;
  logic             audio_lrclk;
  logic             audio_sclk;
  logic             audio_sdin;
  logic             frame_tick;

  modport master (
    output note_div, volume,
    input  audio_mclk, audio_lrclk, audio_sclk, audio_sdin, frame_tick
  );

  modport slave (
    input  note_div, volume,
    output audio_mclk, audio_lrclk, audio_sclk, audio_sdin, frame_tick
  );
endinterface

// File: rtl/tone_i2s_tx.sv
// rtl/tone_i2s_tx.sv - square-wave tone generator serialised as 16-bit stereo I2S
module tone_i2s_tx #(
  parameter int          DIV_W    = 22,
  parameter logic [15:0] AMP_STEP = 16'h0400
) (
  input  logic         clk,
  input  logic         rst,
  tone_i2s_tx_if.slave bus
);
  logic [9:0]       div_cnt_q, div_cnt_d;
  logic [DIV_W-1:0] tone_cnt_q, tone_cnt_d;
  logic [DIV_W-1:0] active_div_q, active_div_d;
  logic [2:0]       active_vol_q, active_vol_d;
  logic             tone_q, tone_d;
  logic [15:0]      sample_q, sample_d;
  logic             sdin_q, sdin_d;

  logic             boundary;
  logic [DIV_W-1:0] half;
  logic [15:0]      amp;
  logic [15:0]      tone_sample;
  logic [4:0]       next_slot;
  logic [3:0]       bit_idx;

  assign boundary    = (div_cnt_q == 10'd1023);
  assign half        = active_div_q >> 1;
  assign amp         = 16'(active_vol_q) * AMP_STEP;
  assign tone_sample = (active_div_q < DIV_W'(2)) ? 16'h0000 : (tone_q ? amp : -amp);

  // Slot n carries sample[(-n) mod 16]: L MSB..LSB in slots 1..16, R MSB..bit1 in 17..31,
  // R LSB in slot 0 of the next frame.
  assign next_slot = div_cnt_q[9:5] + 5'd1;
  assign bit_idx   = 4'(~next_slot + 5'd1);

  always_comb begin
    div_cnt_d    = div_cnt_q + 10'd1;
    active_div_d = active_div_q;
    active_vol_d = active_vol_q;
    sample_d     = sample_q;
    tone_cnt_d   = tone_cnt_q;
    tone_d       = tone_q;
    sdin_d       = sdin_q;

    if (active_div_q < DIV_W'(2)) begin
      tone_cnt_d = '0;
      tone_d     = 1'b0;
    end else if (tone_cnt_q == half - DIV_W'(1)) begin
      tone_cnt_d = '0;
      tone_d     = ~tone_q;
    end else begin
      tone_cnt_d = tone_cnt_q + DIV_W'(1);
    end

    if (boundary) begin
      active_div_d = bus.note_div;
      active_vol_d = bus.volume;
      sample_d     = tone_sample;
      // A new note restarts the phase, overriding any toggle due on this edge.
      if (bus.note_div != active_div_q) begin
        tone_cnt_d = '0;
        tone_d     = 1'b1;
      end
    end

    // At div_cnt 1023 sample_q still holds the previous frame, so slot 0 gets the old R LSB.
    if (div_cnt_q[4:0] == 5'd31) begin
      sdin_d = sample_q[bit_idx];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_q    <= '0;
      tone_cnt_q   <= '0;
      tone_q       <= 1'b0;
      active_div_q <= '0;
      active_vol_q <= '0;
      sample_q     <= '0;
      sdin_q       <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      tone_cnt_q   <= tone_cnt_d;
      tone_q       <= tone_d;
      active_div_q <= active_div_d;
      active_vol_q <= active_vol_d;
      sample_q     <= sample_d;
      sdin_q       <= sdin_d;
    end
  end

  assign bus.audio_mclk  = div_cnt_q[1];
  assign bus.audio_sclk  = div_cnt_q[4];
  assign bus.audio_lrclk = div_cnt_q[9];
  assign bus.audio_sdin  = sdin_q;
  assign bus.frame_tick  = boundary;
endmodule

// File: tb/tb_tone_i2s_tx.sv
// tb/tb_tone_i2s_tx.sv - self-checking bench for tone_i2s_tx with an I2S word decoder and sample model
module tb_tone_i2s_tx;
  localparam int DIV_W = 22;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  tone_i2s_tx_if #(.DIV_W(DIV_W)) bus ();

  tone_i2s_tx #(.DIV_W(DIV_W), .AMP_STEP(16'h0400)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Clock edges seen since reset release; equals the expected div_cnt modulo 1024.
  int unsigned ecount;
  always @(posedge clk or negedge rst) begin
    if (!rst) ecount <= 0;
    else      ecount <= ecount + 1;
  end

  // I2S receiver: shift on SCLK rise; an LRCLK change marks the bit just taken as a word LSB.
  logic        prev_sclk;
  logic        lr_at_rise;
  logic [15:0] sh;
  logic [15:0] words[$];
  int unsigned nd_log[$];
  int unsigned vol_log[$];

  always @(negedge clk) begin
    if (!rst) begin
      prev_sclk  = 1'b0;
      lr_at_rise = 1'b0;
      sh         = 16'h0000;
    end else begin
      if (bus.audio_sclk && !prev_sclk) begin
        sh = {sh[14:0], bus.audio_sdin};
        if (bus.audio_lrclk != lr_at_rise) words.push_back(sh);
        lr_at_rise = bus.audio_lrclk;
      end
      prev_sclk = bus.audio_sclk;
      if ((ecount % 1024) == 1023) begin
        nd_log.push_back(int'(bus.note_div));
        vol_log.push_back(int'(bus.volume));
      end
    end
  end

  // Frame f carries the sample taken at boundary f-1 from the note/volume logged at boundary f-2.
  function automatic logic [15:0] exp_sample(int f);
    int a, v, p, m;
    if (f < 2) return 16'h0000;
    a = int'(nd_log[f-2]);
    v = int'(vol_log[f-2]);
    if (a < 2) return 16'h0000;
    p = f - 2;
    while (p > 0 && nd_log[p-1] == nd_log[f-2]) p--;
    m = 1024 * (f - p - 1) - 1;
    return (((m / (a / 2)) % 2) == 0) ? 16'(v * 1024) : 16'(-(v * 1024));
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_mclk"},  32'(bus.audio_mclk),  0);
    chk({tag, "_sclk"},  32'(bus.audio_sclk),  0);
    chk({tag, "_lrclk"}, 32'(bus.audio_lrclk), 0);
    chk({tag, "_sdin"},  32'(bus.audio_sdin),  0);
    chk({tag, "_tick"},  32'(bus.frame_tick),  0);
  endtask

  task automatic run_timed(int n, bit silent);
    int first_tick = -1;
    int n_ticks = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      chk("mclk",  32'(bus.audio_mclk),  (ecount >> 1) & 1);
      chk("sclk",  32'(bus.audio_sclk),  (ecount >> 4) & 1);
      chk("lrclk", 32'(bus.audio_lrclk), (ecount >> 9) & 1);
      chk("frame_tick", 32'(bus.frame_tick), 32'((ecount % 1024) == 1023));
      if (silent) chk("silent_sdin", 32'(bus.audio_sdin), 0);
      if (bus.frame_tick) begin
        n_ticks++;
        if (first_tick < 0) first_tick = int'(ecount);
      end
    end
    chk("first_tick_clk", 32'(first_tick), 1023);
    chk("tick_count", 32'(n_ticks), 32'(n / 1024));
  endtask

  task automatic wait_div(int d);
    int k = 0;
    while (int'(ecount % 1024) != d && k < 2048) begin
      tick();
      k++;
    end
  endtask

  task automatic check_words(string tag, int min_words);
    logic [15:0] e;
    chk({tag, "_word_count_ok"}, 32'(words.size() >= min_words), 1);
    for (int w = 0; w < words.size(); w++) begin
      e = exp_sample(w / 2);
      n_assert++;
      assert (words[w] === e) else begin
        n_fail++;
        $error("FAIL %s word %0d (%s): observed %h expected %h", tag, w,
               (w % 2) ? "R" : "L", words[w], e);
      end
    end
  endtask

  initial begin
    int frames;
    int unsigned nd;
    int unsigned prev_nd;

    bus.note_div = '0;
    bus.volume   = 3'd7;
    repeat (3) tick();
    chk_all_zero("in_reset");
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_all_zero("after_release");

    // Clock generation with note_div = 0, volume = 7: silence on every slot.
    run_timed(2100, 1'b1);
    frames = 2;

    // C4 at volume 4, changed mid-frame.
    wait_div(400);
    bus.note_div = DIV_W'(191113);
    bus.volume   = 3'd4;
    repeat (4 * 1024) tick();
    frames += 5;

    // Shorter tone so both polarities appear within a few frames.
    bus.note_div = DIV_W'(6000);
    bus.volume   = 3'($urandom_range(1, 7));
    repeat (8 * 1024) tick();
    frames += 8;

    // Random notes changed at div_cnt 400; second pass repeats the note to check continuity.
    prev_nd = 6000;
    for (int i = 0; i < 4; i++) begin
      wait_div(400);
      nd = (i == 1) ? prev_nd : $urandom_range(2, 3000);
      bus.note_div = DIV_W'(nd);
      bus.volume   = 3'($urandom_range(0, 7));
      prev_nd = nd;
      repeat (3 * 1024) tick();
      frames += 3;
    end

    // Edge periods: silence below 2, one-clk half period, and note 4 at volume 1.
    foreach (nd_log[k]) begin end
    bus.note_div = DIV_W'(1);
    bus.volume   = 3'd5;
    repeat (2 * 1024) tick();
    bus.note_div = DIV_W'(3);
    repeat (2 * 1024) tick();
    bus.note_div = DIV_W'(4);
    bus.volume   = 3'd1;
    repeat (3 * 1024) tick();
    frames += 7;

    check_words("run1", 2 * frames - 4);

    // Asynchronous reset mid-frame.
    wait_div(600);
    rst = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    repeat (5) tick();
    chk_all_zero("mid_reset_hold");
    @(negedge clk);
    rst = 1'b1;
    words.delete();
    nd_log.delete();
    vol_log.delete();
    #1;
    chk("restart_div", ecount, 0);
    chk_all_zero("restart");
    bus.note_div = DIV_W'(10);
    bus.volume   = 3'd3;
    run_timed(3 * 1024 + 100, 1'b0);
    check_words("after_reset", 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
